key_encoder: RTL and testbench
==============================

# key_encoder

Converts PS/2 Set-2 scancode bytes into the 4-bit key code consumed by the game state machine's `keyboard` input (ZERO/W/D/S/A/SPACE). Sits between the PS/2 byte receiver and the state machine. Tracks make/break sequences, keeps a held-key bitmap, and presents the most recently pressed, still-held key as a level. It also emits a one-cycle pulse on every new press.

## Interface
Parameters:
- `HOLD_FALLBACK`, default 1: when the shown key is released, 1 = show another held key, 0 = show ZERO.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset_n`  input  1  reset, asynchronous and active-low.
- `scancode`  input  8  byte from PS/2 receiver.
- `scancodeValid`  input  1  one-cycle strobe; `scancode` is valid this cycle.
- `keyboard`  output  4  key code: 0000 ZERO, 0001 W, 0010 D, 0011 S, 0100 A, 0101 SPACE.
- `keyPress`  output  1  one-cycle pulse when a new make code for a mapped key is accepted.
- `heldMask`  output  5  held bitmap, bit0 W, bit1 D, bit2 S, bit3 A, bit4 SPACE.
- `seqError`  output  1  sticky flag for an illegal prefix sequence; cleared only by reset.

## Operation
- Make-code map: 0x1D→W, 0x23→D, 0x1B→S, 0x1C→A, 0x29→SPACE. All other codes are ignored, but they still close any pending prefix.
- Parser FSM states: IDLE, BRK (0xF0 seen), EXT (0xE0 seen), EXTBRK (0xE0 then 0xF0 seen). Transitions occur only on `scancodeValid`.
- IDLE:
  - 0xF0 → BRK.
  - 0xE0 → EXT.
  - Any other byte → process as make, stay IDLE.
- BRK: any byte → process as break → IDLE.
- EXT:
  - 0xF0 → EXTBRK.
  - Any other byte → process as extended make → IDLE.
- EXTBRK: any byte → process as extended break → IDLE.
- Illegal prefixes (0xE0 or 0xF0 received in BRK or EXTBRK, or 0xE0 received in EXT):
  - Set `seqError`.
  - Go to the state that byte would reach from IDLE.
- Make for a mapped key:
  - Set its `heldMask` bit.
  - `keyboard` ← that code.
  - `keyPress` pulses only if the bit was previously clear. Typematic repeats are absorbed.
- Break for a mapped key:
  - Clear its bit.
  - If it was the displayed key and `HOLD_FALLBACK`=1: `keyboard` ← the lowest-encoded remaining held key, or ZERO if none.
  - If it was the displayed key and `HOLD_FALLBACK`=0: `keyboard` ← ZERO.
- Break of a key that is not held: no effect. This is not an error.
- Extended codes are ignored unless `ARROW_KEYS_EN` is defined (see Configuration).

## Timing
- Reset values: `keyboard`=0000, `keyPress`=0, `heldMask`=00000, `seqError`=0, FSM=IDLE.
- Reset is asynchronous: asserting `reset_n` low mid-sequence immediately drops every output to its reset value and discards any pending prefix.
- Latency: the final byte of a sequence, strobed in cycle N, updates `keyboard`, `heldMask` and `keyPress` at the edge ending cycle N. They are visible in cycle N+1.
- `keyPress` is high for exactly one cycle.
- Every output is registered; none is combinational from inputs.
- Back-to-back strobes on consecutive cycles must be accepted without loss.
- `scancode` is don't-care when `scancodeValid`=0.

## Configuration
- `KEY_ENCODER_ARROW_KEYS_EN` defined: extended makes/breaks map to the same keys and the same held bits as WASD.
  - E0 75 → W, E0 74 → D, E0 72 → S, E0 6B → A.
  - Arrow and letter share a bit: the break of either clears the bit.
- Macro undefined: every extended sequence is consumed by the FSM with no effect on outputs.
  - Illegal-prefix detection still applies.

## Test plan
- Reset, then bytes 1D, F0 1D → `keyboard`=0001 one cycle after 1D with a single `keyPress` pulse; `keyboard`=0000 one cycle after the last 1D; `heldMask` ends 00000.
- 1D, 1D, 1D (typematic) → exactly one `keyPress`; `keyboard` stays 0001.
- 1D, 23, F0 23 with `HOLD_FALLBACK`=1 → `keyboard` sequence 0001, 0010, 0001. With `HOLD_FALLBACK`=0 the last value is 0000.
- 29 strobed on consecutive cycles after F0 29 → `keyboard`=0101, then 0000, then 0101, with no byte dropped.
- F0 F0 1D → `seqError`=1, `heldMask` unchanged.
- E0 75 with macro defined → `keyboard`=0001. Without the macro → `keyboard`=0000 and no `keyPress`.

Source files
------------

// File: rtl/key_encoder.sv
// PS/2 Set-2 scancode to game key-code encoder: make/break parser, held-key bitmap, key-press pulse.
// Define KEY_ENCODER_ARROW_KEYS_EN to map the E0-prefixed arrow keys onto the WASD keys.
module key_encoder #(
    parameter int HOLD_FALLBACK = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] scancode,
    input  logic       scancodeValid,
    output logic [3:0] keyboard,
    output logic       keyPress,
    output logic [4:0] heldMask,
    output logic       seqError
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BRK    = 2'd1,
        S_EXT    = 2'd2,
        S_EXTBRK = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] held_q, held_d;
    logic [3:0] kb_q, kb_d;
    logic       kp_q, kp_d;
    logic       err_q, err_d;

    logic       is_f0, is_e0;
    logic       do_make, do_break, ext;
    logic [3:0] key;
    logic [4:0] kmask;

    // Key code 0 means "not a mapped key"; codes 1..5 correspond to heldMask bits 0..4.
    function automatic logic [3:0] map_code(input logic [7:0] code, input logic is_ext);
        logic [3:0] r;
        r = 4'd0;
        if (!is_ext) begin
            case (code)
                8'h1D:   r = 4'd1;
                8'h23:   r = 4'd2;
                8'h1B:   r = 4'd3;
                8'h1C:   r = 4'd4;
                8'h29:   r = 4'd5;
                default: r = 4'd0;
            endcase
        end
`ifdef KEY_ENCODER_ARROW_KEYS_EN
        else begin
            case (code)
                8'h75:   r = 4'd1;
                8'h74:   r = 4'd2;
                8'h72:   r = 4'd3;
                8'h6B:   r = 4'd4;
                default: r = 4'd0;
            endcase
        end
`endif
        return r;
    endfunction

    function automatic logic [3:0] lowest_held(input logic [4:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 4; i >= 0; i--) begin
            if (m[i]) r = 4'(i + 1);
        end
        return r;
    endfunction

    assign is_f0 = (scancode == 8'hF0);
    assign is_e0 = (scancode == 8'hE0);

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        kb_d     = kb_q;
        kp_d     = 1'b0;
        err_d    = err_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        ext      = 1'b0;

        if (scancodeValid) begin
            case (state_q)
                S_IDLE: begin
                    if (is_f0)      state_d = S_BRK;
                    else if (is_e0) state_d = S_EXT;
                    else            do_make = 1'b1;
                end
                S_BRK: begin
                    if (is_f0) begin
                        err_d   = 1'b1;
                        state_d = S_BRK;
                    end else if (is_e0) begin
                        err_d   = 1'b1;
                        state_d = S_EXT;
                    end else begin
                        do_break = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                S_EXT: begin
                    if (is_f0) begin
                        state_d = S_EXTBRK;
                    end else if (is_e0) begin
                        err_d   = 1'b1;
                        state_d = S_EXT;
                    end else begin
                        do_make = 1'b1;
                        ext     = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_EXTBRK: begin
                    if (is_f0) begin
                        err_d   = 1'b1;
                        state_d = S_BRK;
                    end else if (is_e0) begin
                        err_d   = 1'b1;
                        state_d = S_EXT;
                    end else begin
                        do_break = 1'b1;
                        ext      = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        key   = map_code(scancode, ext);
        kmask = (key == 4'd0) ? 5'd0 : 5'(5'b00001 << (key - 4'd1));

        // Typematic repeats re-assert the bit but do not pulse keyPress.
        if (do_make && (kmask != 5'd0)) begin
            held_d = held_q | kmask;
            kb_d   = key;
            kp_d   = ((held_q & kmask) == 5'd0);
        end

        if (do_break && ((held_q & kmask) != 5'd0)) begin
            held_d = held_q & ~kmask;
            if (kb_q == key) begin
                kb_d = (HOLD_FALLBACK != 0) ? lowest_held(held_d) : 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            held_q  <= 5'd0;
            kb_q    <= 4'd0;
            kp_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            kb_q    <= kb_d;
            kp_q    <= kp_d;
            err_q   <= err_d;
        end
    end

    assign keyboard = kb_q;
    assign keyPress = kp_q;
    assign heldMask = held_q;
    assign seqError = err_q;

endmodule

// File: tb/tb_key_encoder.sv
// Scoreboard bench for key_encoder: expectations queued per strobe, compared one cycle later.
// Two instances share stimulus: HOLD_FALLBACK=1 (main) and HOLD_FALLBACK=0.
module tb_key_encoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic       scancodeValid = 1'b0;

    logic [3:0] keyboard, keyboard0;
    logic       keyPress, keyPress0;
    logic [4:0] heldMask, heldMask0;
    logic       seqError, seqError0;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0] kb;
        logic       kp;
        logic [4:0] held;
        logic       err;
        logic [3:0] kb0;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    key_encoder #(.HOLD_FALLBACK(1)) dut (
        .clk(clk), .reset_n(reset_n), .scancode(scancode), .scancodeValid(scancodeValid),
        .keyboard(keyboard), .keyPress(keyPress), .heldMask(heldMask), .seqError(seqError)
    );

    key_encoder #(.HOLD_FALLBACK(0)) dut_nf (
        .clk(clk), .reset_n(reset_n), .scancode(scancode), .scancodeValid(scancodeValid),
        .keyboard(keyboard0), .keyPress(keyPress0), .heldMask(heldMask0), .seqError(seqError0)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one byte on the falling edge and queue what must be visible after the next rising edge.
    task automatic send(input logic [7:0] code, input logic [3:0] kb, input logic kp,
                        input logic [4:0] held, input logic err, input logic [3:0] kb0);
        exp_t e;
        @(negedge clk);
        scancode      = code;
        scancodeValid = 1'b1;
        e.kb = kb; e.kp = kp; e.held = held; e.err = err; e.kb0 = kb0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        scancodeValid = 1'b0;
        scancode      = 8'hXX;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_val("idle_keyPress", {31'd0, keyPress}, 32'd0);
        end
    endtask

    always @(posedge clk) begin
        if (scancodeValid && reset_n) begin
            exp_t e;
            #1;
            if (exp_q.size() == 0) begin
                check_val("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("keyboard", {28'd0, keyboard}, {28'd0, e.kb});
                check_val("keyPress", {31'd0, keyPress}, {31'd0, e.kp});
                check_val("heldMask", {27'd0, heldMask}, {27'd0, e.held});
                check_val("seqError", {31'd0, seqError}, {31'd0, e.err});
                check_val("keyboard_nofallback", {28'd0, keyboard0}, {28'd0, e.kb0});
            end
        end
    end

    initial begin
        #12;
        check_val("rst_keyboard", {28'd0, keyboard}, 32'd0);
        check_val("rst_keyPress", {31'd0, keyPress}, 32'd0);
        check_val("rst_heldMask", {27'd0, heldMask}, 32'd0);
        check_val("rst_seqError", {31'd0, seqError}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        // Press and release W
        send(8'h1D, 4'd1, 1'b1, 5'b00001, 1'b0, 4'd1);
        send(8'hF0, 4'd1, 1'b0, 5'b00001, 1'b0, 4'd1);
        send(8'h1D, 4'd0, 1'b0, 5'b00000, 1'b0, 4'd0);
        idle(2);

        // Typematic repeats
        send(8'h1D, 4'd1, 1'b1, 5'b00001, 1'b0, 4'd1);
        idle(1);
        send(8'h1D, 4'd1, 1'b0, 5'b00001, 1'b0, 4'd1);
        send(8'h1D, 4'd1, 1'b0, 5'b00001, 1'b0, 4'd1);
        send(8'hF0, 4'd1, 1'b0, 5'b00001, 1'b0, 4'd1);
        send(8'h1D, 4'd0, 1'b0, 5'b00000, 1'b0, 4'd0);
        idle(1);

        // Two held keys; releasing the displayed one falls back (or not)
        send(8'h1D, 4'd1, 1'b1, 5'b00001, 1'b0, 4'd1);
        send(8'h23, 4'd2, 1'b1, 5'b00011, 1'b0, 4'd2);
        send(8'hF0, 4'd2, 1'b0, 5'b00011, 1'b0, 4'd2);
        send(8'h23, 4'd1, 1'b0, 5'b00001, 1'b0, 4'd0);
        send(8'h15, 4'd1, 1'b0, 5'b00001, 1'b0, 4'd0);
        send(8'hF0, 4'd1, 1'b0, 5'b00001, 1'b0, 4'd0);
        send(8'h1D, 4'd0, 1'b0, 5'b00000, 1'b0, 4'd0);
        idle(1);

        // Back-to-back SPACE traffic, starting with a break of an unheld key
        send(8'hF0, 4'd0, 1'b0, 5'b00000, 1'b0, 4'd0);
        send(8'h29, 4'd0, 1'b0, 5'b00000, 1'b0, 4'd0);
        send(8'h29, 4'd5, 1'b1, 5'b10000, 1'b0, 4'd5);
        send(8'hF0, 4'd5, 1'b0, 5'b10000, 1'b0, 4'd5);
        send(8'h29, 4'd0, 1'b0, 5'b00000, 1'b0, 4'd0);
        send(8'h29, 4'd5, 1'b1, 5'b10000, 1'b0, 4'd5);
        send(8'h1B, 4'd3, 1'b1, 5'b10100, 1'b0, 4'd3);
        send(8'h1C, 4'd4, 1'b1, 5'b11100, 1'b0, 4'd4);
        send(8'hF0, 4'd4, 1'b0, 5'b11100, 1'b0, 4'd4);
        send(8'h1C, 4'd3, 1'b0, 5'b10100, 1'b0, 4'd0);
        send(8'hF0, 4'd3, 1'b0, 5'b10100, 1'b0, 4'd0);
        send(8'h1B, 4'd5, 1'b0, 5'b10000, 1'b0, 4'd0);
        send(8'hF0, 4'd5, 1'b0, 5'b10000, 1'b0, 4'd0);
        send(8'h29, 4'd0, 1'b0, 5'b00000, 1'b0, 4'd0);
        idle(1);

        // Illegal double F0 with D held
        send(8'h23, 4'd2, 1'b1, 5'b00010, 1'b0, 4'd2);
        send(8'hF0, 4'd2, 1'b0, 5'b00010, 1'b0, 4'd2);
        send(8'hF0, 4'd2, 1'b0, 5'b00010, 1'b1, 4'd2);
        send(8'h1D, 4'd2, 1'b0, 5'b00010, 1'b1, 4'd2);
        send(8'hF0, 4'd2, 1'b0, 5'b00010, 1'b1, 4'd2);
        send(8'h23, 4'd0, 1'b0, 5'b00000, 1'b1, 4'd0);
        idle(1);

        // Extended make/break of the up arrow
        send(8'hE0, 4'd0, 1'b0, 5'b00000, 1'b1, 4'd0);
`ifdef KEY_ENCODER_ARROW_KEYS_EN
        send(8'h75, 4'd1, 1'b1, 5'b00001, 1'b1, 4'd1);
        send(8'hE0, 4'd1, 1'b0, 5'b00001, 1'b1, 4'd1);
        send(8'hF0, 4'd1, 1'b0, 5'b00001, 1'b1, 4'd1);
        send(8'h75, 4'd0, 1'b0, 5'b00000, 1'b1, 4'd0);
`else
        send(8'h75, 4'd0, 1'b0, 5'b00000, 1'b1, 4'd0);
        send(8'hE0, 4'd0, 1'b0, 5'b00000, 1'b1, 4'd0);
        send(8'hF0, 4'd0, 1'b0, 5'b00000, 1'b1, 4'd0);
        send(8'h75, 4'd0, 1'b0, 5'b00000, 1'b1, 4'd0);
`endif
        idle(1);

        // Asynchronous reset with W held and a break prefix pending
        send(8'h1D, 4'd1, 1'b1, 5'b00001, 1'b1, 4'd1);
        send(8'hF0, 4'd1, 1'b0, 5'b00001, 1'b1, 4'd1);
        idle(1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_keyboard", {28'd0, keyboard}, 32'd0);
        check_val("arst_heldMask", {27'd0, heldMask}, 32'd0);
        check_val("arst_seqError", {31'd0, seqError}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        send(8'h1D, 4'd1, 1'b1, 5'b00001, 1'b0, 4'd1);
        idle(2);

        check_val("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish within 50000");
        $fatal(1, "timeout");
    end

endmodule
